alu_xfer_sequencer: RTL and testbench



---
 rtl/cpu_ops_pkg.sv | 27 ++
 rtl/alu_xfer_sequencer_if.sv | 32 +++
 rtl/alu_xfer_sequencer_idx_to_onehot.sv | 11 +
 rtl/alu_xfer_sequencer.sv | 83 ++++++++
 tb/tb_alu_xfer_sequencer.sv | 108 ++++++++++
 5 files changed

// File: rtl/cpu_ops_pkg.sv
// cpu_ops_pkg: opcode constants and sequencer state encoding shared by the ALU transfer path
package cpu_ops_pkg;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_SHR  = 4;
  localparam int OP_SHRA = 5;
  localparam int OP_SHL  = 6;
  localparam int OP_ROR  = 7;
  localparam int OP_ROL  = 8;
  localparam int OP_MUL  = 9;
  localparam int OP_DIV  = 10;
  localparam int OP_NEG  = 11;
  localparam int OP_NOT  = 12;
  localparam int OP_LAST = 12;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_SRC1  = 3'd1,
    S_EXE   = 3'd2,
    S_WB    = 3'd3,
    S_WB_LO = 3'd4,
    S_WB_HI = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;
endpackage

// File: rtl/alu_xfer_sequencer_if.sv
// alu_xfer_sequencer_if: request fields from decode and datapath strobes back to registers
interface alu_xfer_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OP_W = 5,
  parameter int IDX_W = 4
);
  logic start;
  logic [OP_W-1:0] opcode;
  logic [IDX_W-1:0] rd;
  logic [IDX_W-1:0] rs;
  logic [IDX_W-1:0] rt;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic y_in;
  logic z_in;
  logic zlo_out;
  logic zhi_out;
  logic lo_in;
  logic hi_in;
  logic [OP_W-1:0] alu_op;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, opcode, rd, rs, rt,
    input reg_out, reg_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, alu_op, busy, done, err
  );
  modport slave (
    input start, opcode, rd, rs, rt,
    output reg_out, reg_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, alu_op, busy, done, err
  );
endinterface

// File: rtl/alu_xfer_sequencer_idx_to_onehot.sv
// idx_to_onehot: register index to one-hot enable vector, all zero when disabled
module idx_to_onehot #(
  parameter int IDX_W = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);
  assign onehot = en ? (NUM_REGS'(1) << idx) : '0;
endmodule

// File: rtl/alu_xfer_sequencer.sv
// alu_xfer_sequencer: sequences one register-to-register ALU op over the shared bus
module alu_xfer_sequencer
  import cpu_ops_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W = 5,
  parameter int IDX_W = 4
) (
  input logic clock,
  input logic clear,
  alu_xfer_sequencer_if.slave bus
);
  state_t state;
  state_t nxt;
  logic [OP_W-1:0] op_q;
  logic [IDX_W-1:0] rd_q;
  logic [IDX_W-1:0] rs_q;
  logic [IDX_W-1:0] rt_q;
  logic un_q;
  logic md_q;
  logic un_in;
  logic bad_in;
  logic out_en;
  logic in_en;
  logic [IDX_W-1:0] out_idx;
  assign un_in  = bus.opcode == OP_W'(OP_NEG) || bus.opcode == OP_W'(OP_NOT);
  assign bad_in = bus.opcode > OP_W'(OP_LAST);
  assign un_q   = op_q == OP_W'(OP_NEG) || op_q == OP_W'(OP_NOT);
  assign md_q   = op_q == OP_W'(OP_MUL) || op_q == OP_W'(OP_DIV);
  // state register; clear forces IDLE regardless of start
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else state <= nxt;
  end
  // request fields are captured only when a start is accepted in IDLE
  always_ff @(posedge clock) begin
    if (clear) begin
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
    end else if (state == IDLE && bus.start) begin
      op_q <= bus.opcode;
      rd_q <= bus.rd;
      rs_q <= bus.rs;
      rt_q <= bus.rt;
    end
  end
  // next-state walk: unary ops skip the Y load, MUL/DIV split write-back into LO/HI
  always_comb begin
    nxt = state == IDLE    ? (!bus.start ? IDLE : bad_in ? S_ERR : un_in ? S_EXE : S_SRC1) :
          state == S_SRC1  ? S_EXE :
          state == S_EXE   ? (md_q ? S_WB_LO : S_WB) :
          state == S_WB_LO ? S_WB_HI :
          (state == S_WB || state == S_WB_HI) ? S_DONE : IDLE;
  end
  // strobes decode from state and latched fields only, so live inputs never glitch them
  always_comb begin
    out_en      = state == S_SRC1 || state == S_EXE;
    out_idx     = (state == S_EXE && !un_q) ? rt_q : rs_q;
    in_en       = state == S_WB;
    bus.y_in    = state == S_SRC1;
    bus.z_in    = state == S_EXE;
    bus.zlo_out = state == S_WB || state == S_WB_LO;
    bus.zhi_out = state == S_WB_HI;
    bus.lo_in   = state == S_WB_LO;
    bus.hi_in   = state == S_WB_HI;
    bus.alu_op  = state == S_EXE ? op_q : '0;
    bus.busy    = state != IDLE;
    bus.done    = state == S_DONE;
    bus.err     = state == S_ERR;
  end
  idx_to_onehot #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_out_dec (
    .en(out_en),
    .idx(out_idx),
    .onehot(bus.reg_out)
  );
  idx_to_onehot #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_in_dec (
    .en(in_en),
    .idx(rd_q),
    .onehot(bus.reg_in)
  );
endmodule

// File: tb/tb_alu_xfer_sequencer.sv
// tb_alu_xfer_sequencer: directed and random ops checked against a per-cycle expected-output queue
module tb_alu_xfer_sequencer;
  typedef struct packed {
    logic [15:0] ro;
    logic [15:0] ri;
    logic y;
    logic z;
    logic zl;
    logic zh;
    logic lo;
    logic hi;
    logic [4:0] op;
    logic busy;
    logic done;
    logic err;
  } out_t;
  logic clock = 0;
  logic clear = 1;
  int n_cmp = 0;
  int n_bad = 0;
  out_t exp_q[$];
  alu_xfer_sequencer_if #(.NUM_REGS(16), .OP_W(5), .IDX_W(4)) b ();
  alu_xfer_sequencer #(.NUM_REGS(16), .OP_W(5), .IDX_W(4)) dut (
    .clock(clock),
    .clear(clear),
    .bus(b)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic plan(input int op, input int d, input int s, input int t);
    out_t v;
    bit un = op == 11 || op == 12;
    bit md = op == 9 || op == 10;
    if (op > 12) begin
      v = '0; v.err = 1; v.busy = 1; exp_q.push_back(v);
    end else begin
      if (!un) begin
        v = '0; v.ro = 16'(1) << s; v.y = 1; v.busy = 1; exp_q.push_back(v);
      end
      v = '0; v.ro = 16'(1) << (un ? s : t); v.z = 1; v.op = 5'(op); v.busy = 1; exp_q.push_back(v);
      if (md) begin
        v = '0; v.zl = 1; v.lo = 1; v.busy = 1; exp_q.push_back(v);
        v = '0; v.zh = 1; v.hi = 1; v.busy = 1; exp_q.push_back(v);
      end else begin
        v = '0; v.zl = 1; v.ri = 16'(1) << d; v.busy = 1; exp_q.push_back(v);
      end
      v = '0; v.done = 1; v.busy = 1; exp_q.push_back(v);
    end
    exp_q.push_back('0);
  endtask
  task automatic step(input bit clr, input bit st, input int op, input int d, input int s, input int t);
    out_t obs;
    out_t ex;
    int drivers;
    @(negedge clock);
    clear = clr;
    b.start = st;
    b.opcode = 5'(op);
    b.rd = 4'(d);
    b.rs = 4'(s);
    b.rt = 4'(t);
    if (clr) exp_q.delete();
    else if (st && exp_q.size() == 0) plan(op, d, s, t);
    @(posedge clock);
    #1;
    ex = exp_q.size() != 0 ? exp_q.pop_front() : '0;
    obs = {b.reg_out, b.reg_in, b.y_in, b.z_in, b.zlo_out, b.zhi_out, b.lo_in, b.hi_in,
           b.alu_op, b.busy, b.done, b.err};
    check("outputs", 64'(obs), 64'(ex));
    drivers = int'(b.reg_out != 0) + int'(b.zlo_out) + int'(b.zhi_out);
    check("one_driver", 64'(drivers <= 1), 64'(1));
  endtask
  initial begin
    b.start = 0; b.opcode = 0; b.rd = 0; b.rs = 0; b.rt = 0;
    step(1, 1, 0, 3, 1, 2);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3, 1, 2);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 12, 5, 5, 9);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 9, 1, 6, 7);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 20, 1, 2, 3);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3, 1, 2);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 4, 2, 3);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3, 1, 2);
    for (int i = 0; i < 8; i++) step(0, 1, 6 + i, 15 - i, i, i + 1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0 ? $urandom_range(13, 31) : $urandom_range(0, 12),
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    repeat (8) step(0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
